// File: rtl/ser_arb_pkg.sv
// Shared types and defaults for the serializer arbiter.
package ser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } arb_state_t;

  localparam int DEF_LOGWIDTH = 5;

  // Index reached by stepping 'off' places from 'base', wrapping at n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set Req bit at or after Ptr, wrapping.
module rr_pick import ser_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] Req,
  input  logic [IDXW-1:0] Ptr,
  output logic [IDXW-1:0] Winner,
  output logic            Valid
);

  // Scan from the farthest offset down so the closest requester wins last.
  always_comb begin
    Winner = '0;
    Valid  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (Req[wrap_idx(int'(Ptr), k, NREQ)]) begin
        Winner = IDXW'(wrap_idx(int'(Ptr), k, NREQ));
        Valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin arbiter feeding one shared serializer (IDLE -> START -> SHIFT).
// Optional start timeout with sticky Err: define SER_ARB_TIMEOUT_EN.
module ser_arbiter import ser_arb_pkg::*; #(
  parameter int NREQ     = 4,
  parameter int LOGWIDTH = DEF_LOGWIDTH,
  parameter int TMO_CYC  = 8
) (
  input  logic                         Clk,
  input  logic                         Srst,
  input  logic [NREQ-1:0]              Req,
  input  logic [NREQ*(2**LOGWIDTH)-1:0] Data,
  output logic [NREQ-1:0]              Grant,
  output logic                         Ser_Init,
  output logic [(2**LOGWIDTH)-1:0]     Ser_Data,
  input  logic                         Ser_Ready,
  output logic                         Busy,
`ifdef SER_ARB_TIMEOUT_EN
  output logic                         Err,
`endif
  output logic [$clog2(NREQ)-1:0]      Owner
);

  localparam int W    = 2**LOGWIDTH;
  localparam int IDXW = $clog2(NREQ);

  arb_state_t      state_reg, state_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [W-1:0]    ser_data_reg, ser_data_next;
  logic [IDXW-1:0] owner_reg, owner_next;
  logic [IDXW-1:0] pick_idx;
  logic            pick_valid;
  logic [W-1:0]    data_words [NREQ];

`ifdef SER_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TMO_CYC + 1);
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            err_reg, err_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_words
      assign data_words[gi] = Data[gi*W +: W];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .Req    (Req),
    .Ptr    (ptr_reg),
    .Winner (pick_idx),
    .Valid  (pick_valid)
  );

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_next    = '0;
    ser_data_next = ser_data_reg;
    owner_next    = owner_reg;
`ifdef SER_ARB_TIMEOUT_EN
    cnt_next      = cnt_reg;
    err_next      = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (Ser_Ready && pick_valid) begin
          grant_next[pick_idx] = 1'b1;
          ser_data_next        = data_words[pick_idx];
          owner_next           = pick_idx;
          ptr_next             = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + IDXW'(1);
          state_next           = START;
`ifdef SER_ARB_TIMEOUT_EN
          cnt_next             = '0;
`endif
        end
      end
      START: begin
        if (!Ser_Ready) begin
          state_next = SHIFT;
        end
`ifdef SER_ARB_TIMEOUT_EN
        // Serializer never acknowledged the start: give up and flag it.
        else if (cnt_reg == CNTW'(TMO_CYC - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNTW'(1);
        end
`endif
      end
      SHIFT: begin
        if (Ser_Ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Srst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      ser_data_reg <= '0;
      owner_reg    <= '0;
`ifdef SER_ARB_TIMEOUT_EN
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_reg    <= grant_next;
      ser_data_reg <= ser_data_next;
      owner_reg    <= owner_next;
`ifdef SER_ARB_TIMEOUT_EN
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
`endif
    end
  end

  // Ser_Init is decoded from the registered state, so it drops with the move to SHIFT.
  assign Grant    = grant_reg;
  assign Ser_Init = (state_reg == START);
  assign Ser_Data = ser_data_reg;
  assign Owner    = owner_reg;
  assign Busy     = (state_reg != IDLE);
`ifdef SER_ARB_TIMEOUT_EN
  assign Err      = err_reg;
`endif

endmodule

// File: tb/tb_ser_arbiter.sv
// Directed self-checking bench for ser_arbiter (NREQ=4, 32-bit words).
module tb_ser_arbiter;

  logic         Clk;
  logic         Srst;
  logic [3:0]   Req;
  logic [127:0] Data;
  logic [3:0]   Grant;
  logic         Ser_Init;
  logic [31:0]  Ser_Data;
  logic         Ser_Ready;
  logic         Busy;
  logic [1:0]   Owner;
`ifdef SER_ARB_TIMEOUT_EN
  logic         Err;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;
  localparam logic [31:0] W2 = 32'hDEAD_BEEF;
  localparam logic [31:0] W3 = 32'h4444_4444;

  ser_arbiter #(.NREQ(4), .LOGWIDTH(5), .TMO_CYC(8)) dut (
    .Clk       (Clk),
    .Srst      (Srst),
    .Req       (Req),
    .Data      (Data),
    .Grant     (Grant),
    .Ser_Init  (Ser_Init),
    .Ser_Data  (Ser_Data),
    .Ser_Ready (Ser_Ready),
    .Busy      (Busy),
`ifdef SER_ARB_TIMEOUT_EN
    .Err       (Err),
`endif
    .Owner     (Owner)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic show(input string what);
    $display("txn %-10s req=%b rdy=%b grant=%b init=%b busy=%b owner=%0d data=%h",
             what, Req, Ser_Ready, Grant, Ser_Init, Busy, Owner, Ser_Data);
  endtask

  logic [3:0] exp_order [5];

  initial begin
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    Srst = 1'b1; Req = '0; Ser_Ready = 1'b0;
    Data = {W3, W2, W1, W0};

    // Reset for three cycles
    repeat (3) step();
    show("reset");
    chk("rst_grant", 32'(Grant), 32'h0);
    chk("rst_init",  32'(Ser_Init), 32'h0);
    chk("rst_data",  Ser_Data, 32'h0);
    chk("rst_owner", 32'(Owner), 32'h0);
    chk("rst_busy",  32'(Busy), 32'h0);

    // Requests while serializer not ready: no grant
    Srst = 1'b0; Req = 4'b1111; Ser_Ready = 1'b0;
    repeat (2) begin
      step();
      show("notready");
      chk("nr_grant", 32'(Grant), 32'h0);
      chk("nr_busy",  32'(Busy), 32'h0);
    end

    // Single requester 2
    Req = 4'b0100; Ser_Ready = 1'b1;
    step(); show("single");
    chk("s_grant", 32'(Grant), 32'h4);
    chk("s_data",  Ser_Data, W2);
    chk("s_owner", 32'(Owner), 32'd2);
    chk("s_init",  32'(Ser_Init), 32'h1);
    chk("s_busy",  32'(Busy), 32'h1);
    Req = 4'b0000;
    step(); show("start");
    chk("s_pulse", 32'(Grant), 32'h0);
    chk("s_init_hold", 32'(Ser_Init), 32'h1);
    Ser_Ready = 1'b0;
    step(); show("shift");
    chk("s_init_drop", 32'(Ser_Init), 32'h0);
    chk("s_shift_busy", 32'(Busy), 32'h1);
    Ser_Ready = 1'b1;
    step(); show("idle");
    chk("s_idle_busy", 32'(Busy), 32'h0);
    chk("s_data_hold", Ser_Data, W2);

    // Wrap: pointer is 3, requesters 0 and 1
    Req = 4'b0011;
    step(); show("wrap");
    chk("w_grant", 32'(Grant), 32'h1);
    chk("w_owner", 32'(Owner), 32'd0);
    chk("w_data",  Ser_Data, W0);
    Req = 4'b0010; Ser_Ready = 1'b0;
    step();
    Ser_Ready = 1'b1;
    step();
    Req = 4'b0011;
    step(); show("wrap_next");
    chk("w_ptr1_grant", 32'(Grant), 32'h2);
    chk("w_ptr1_data",  Ser_Data, W1);
    Req = 4'b0000; Ser_Ready = 1'b0;
    step();
    Ser_Ready = 1'b1;
    step();

    // Fairness from a fresh pointer
    Srst = 1'b1; step(); Srst = 1'b0;
    Req = 4'b1111; Ser_Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); show("fair");
      chk("f_grant", 32'(Grant), 32'(exp_order[i]));
      Req = 4'b1111 & ~exp_order[i]; Ser_Ready = 1'b0;
      step();
      Req = 4'b1111; Ser_Ready = 1'b1;
      step();
    end

    // Abort from SHIFT
    step(); show("pre_abort");
    chk("a_grant", 32'(Grant), 32'h2);
    chk("a_owner", 32'(Owner), 32'd1);
    Req = 4'b1101; Ser_Ready = 1'b0;
    step();
    chk("a_shift_busy", 32'(Busy), 32'h1);
    Srst = 1'b1;
    step(); show("abort");
    chk("a_busy",  32'(Busy), 32'h0);
    chk("a_data",  Ser_Data, 32'h0);
    chk("a_owner0", 32'(Owner), 32'h0);
    chk("a_init",  32'(Ser_Init), 32'h0);
    Srst = 1'b0; Req = 4'b1111;
    repeat (2) begin
      step();
      chk("a_wait_grant", 32'(Grant), 32'h0);
    end
    Ser_Ready = 1'b1;
    step(); show("post_abort");
    chk("a_regrant", 32'(Grant), 32'h1);
    chk("a_redata",  Ser_Data, W0);

`ifdef SER_ARB_TIMEOUT_EN
    Srst = 1'b1; Req = 4'b0000; step(); Srst = 1'b0;
    Req = 4'b0001; Ser_Ready = 1'b1;
    step(); show("tmo_grant");
    chk("t_grant", 32'(Grant), 32'h1);
    chk("t_err0",  32'(Err), 32'h0);
    Req = 4'b0000;
    repeat (7) step();
    chk("t_init_pre", 32'(Ser_Init), 32'h1);
    chk("t_err_pre",  32'(Err), 32'h0);
    step(); show("timeout");
    chk("t_init", 32'(Ser_Init), 32'h0);
    chk("t_err",  32'(Err), 32'h1);
    chk("t_busy", 32'(Busy), 32'h0);
    step();
    chk("t_sticky", 32'(Err), 32'h1);
    Srst = 1'b1; step(); Srst = 1'b0;
    chk("t_clr", 32'(Err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
